// File: rtl/airlock_interlock_ctrl_if.sv
// Switch/key stimulus bundle between the lab tester and the airlock interlock controller.
// The master is the tester driving switches/keys; the slave is the controller driving doors, pump and LEDs.
interface airlock_interlock_ctrl_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 sw0;
    logic                 sw1;
    logic                 sw2;
    logic                 key0;
    logic                 key1;
    logic                 key2;
    logic                 outer_door_open;
    logic                 inner_door_open;
    logic                 pumping;
    logic                 venting;
    logic                 pressurized;
    logic                 reject;
    logic [CNT_WIDTH-1:0] remaining;

    modport master (
        output sw0, sw1, sw2, key0, key1, key2,
        input  outer_door_open, inner_door_open, pumping, venting,
               pressurized, reject, remaining
    );

    modport slave (
        input  sw0, sw1, sw2, key0, key1, key2,
        output outer_door_open, inner_door_open, pumping, venting,
               pressurized, reject, remaining
    );
endinterface

// File: rtl/airlock_interlock_ctrl.sv
// Two-door airlock sequencer with pump/vent phase timing and door interlock.
// Optional macro AIRLOCK_AUTO_CLOSE_EN adds a door-open timeout with re-arm on switch toggle.
//
// state        | meaning
// PRESS_IDLE   | chamber pressurized, inner door may open
// EVACUATING   | venting, both doors closed, counting down
// EVAC_IDLE    | chamber evacuated, outer door may open
// PRESSURIZING | pumping, both doors closed, counting down
module airlock_interlock_ctrl #(
    parameter int PRESS_CYCLES = 8,
    parameter int EVAC_CYCLES  = 10,
    parameter int CNT_WIDTH    = 8,
    parameter int DOOR_TIMEOUT = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    airlock_interlock_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        PRESS_IDLE   = 2'd0,
        EVACUATING   = 2'd1,
        EVAC_IDLE    = 2'd2,
        PRESSURIZING = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] PRESS_LOAD = CNT_WIDTH'(PRESS_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] EVAC_LOAD  = CNT_WIDTH'(EVAC_CYCLES - 1);

    state_t               state, state_n;
    logic [2:0]           key_now, key_prev, key_ev;
    logic                 outer_q, outer_n;
    logic                 inner_q, inner_n;
    logic                 pump_q, pump_n;
    logic                 vent_q, vent_n;
    logic                 press_q, press_n;
    logic                 reject_q, reject_n;
    logic [CNT_WIDTH-1:0] remaining_q, remaining_n;
    logic                 outer_req, inner_req;

    assign key_now = {bus.key2, bus.key1, bus.key0};
    assign key_ev  = key_now & ~key_prev;

`ifdef AIRLOCK_AUTO_CLOSE_EN
    localparam logic [CNT_WIDTH-1:0] DOOR_LOAD = CNT_WIDTH'(DOOR_TIMEOUT - 1);

    logic [CNT_WIDTH-1:0] door_timer_q, door_timer_n;
    logic                 outer_lock_q, outer_lock_n;
    logic                 inner_lock_q, inner_lock_n;

    // A timed-out door is locked out until its switch has been seen low.
    assign outer_req = bus.sw0 & ~outer_lock_q;
    assign inner_req = bus.sw1 & ~inner_lock_q;
`else
    assign outer_req = bus.sw0;
    assign inner_req = bus.sw1;
`endif

    always_ff @(posedge clk) begin
        key_prev <= key_now;
        if (rst) begin
            state       <= PRESS_IDLE;
            outer_q     <= 1'b0;
            inner_q     <= 1'b0;
            pump_q      <= 1'b0;
            vent_q      <= 1'b0;
            press_q     <= 1'b1;
            reject_q    <= 1'b0;
            remaining_q <= '0;
        end else begin
            state       <= state_n;
            outer_q     <= outer_n;
            inner_q     <= inner_n;
            pump_q      <= pump_n;
            vent_q      <= vent_n;
            press_q     <= press_n;
            reject_q    <= reject_n;
            remaining_q <= remaining_n;
        end
    end

`ifdef AIRLOCK_AUTO_CLOSE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            door_timer_q <= '0;
            outer_lock_q <= 1'b0;
            inner_lock_q <= 1'b0;
        end else begin
            door_timer_q <= door_timer_n;
            outer_lock_q <= outer_lock_n;
            inner_lock_q <= inner_lock_n;
        end
    end
`endif

    always_comb begin
        state_n     = state;
        remaining_n = remaining_q;
        outer_n     = 1'b0;
        inner_n     = 1'b0;
        pump_n      = 1'b0;
        vent_n      = 1'b0;
        press_n     = 1'b0;
        reject_n    = 1'b0;
`ifdef AIRLOCK_AUTO_CLOSE_EN
        door_timer_n = '0;
        outer_lock_n = outer_lock_q & bus.sw0;
        inner_lock_n = inner_lock_q & bus.sw1;
`endif

        case (state)
            PRESS_IDLE: begin
                press_n     = 1'b1;
                inner_n     = inner_req;
                remaining_n = '0;
                if (key_ev[1]) begin
                    if (!bus.sw1 && !inner_q) begin
                        state_n     = EVACUATING;
                        remaining_n = EVAC_LOAD;
                        vent_n      = 1'b1;
                        press_n     = 1'b0;
                        inner_n     = 1'b0;
                    end else begin
                        reject_n = 1'b1;
                    end
                end
            end

            EVACUATING: begin
                if (key_ev[2]) begin
                    state_n     = PRESSURIZING;
                    remaining_n = PRESS_LOAD;
                    pump_n      = 1'b1;
                end else if (bus.sw2) begin
                    vent_n = 1'b1;
                end else if (remaining_q == '0) begin
                    state_n = EVAC_IDLE;
                end else begin
                    remaining_n = remaining_q - 1'b1;
                    vent_n      = 1'b1;
                end
            end

            EVAC_IDLE: begin
                outer_n     = outer_req;
                remaining_n = '0;
                if (key_ev[0]) begin
                    if (!bus.sw0 && !outer_q) begin
                        state_n     = PRESSURIZING;
                        remaining_n = PRESS_LOAD;
                        pump_n      = 1'b1;
                        outer_n     = 1'b0;
                    end else begin
                        reject_n = 1'b1;
                    end
                end
            end

            PRESSURIZING: begin
                if (key_ev[2]) begin
                    state_n     = EVACUATING;
                    remaining_n = EVAC_LOAD;
                    vent_n      = 1'b1;
                end else if (bus.sw2) begin
                    pump_n = 1'b1;
                end else if (remaining_q == '0) begin
                    state_n = PRESS_IDLE;
                    press_n = 1'b1;
                end else begin
                    remaining_n = remaining_q - 1'b1;
                    pump_n      = 1'b1;
                end
            end

            default: begin
                state_n     = PRESS_IDLE;
                remaining_n = '0;
                press_n     = 1'b1;
            end
        endcase

`ifdef AIRLOCK_AUTO_CLOSE_EN
        // Only one door can be open at a time, so a single timer serves both.
        if (outer_q && outer_n && door_timer_q == '0) begin
            outer_n      = 1'b0;
            outer_lock_n = 1'b1;
        end
        if (inner_q && inner_n && door_timer_q == '0) begin
            inner_n      = 1'b0;
            inner_lock_n = 1'b1;
        end
        if ((outer_n || inner_n) && !(outer_q || inner_q)) begin
            door_timer_n = DOOR_LOAD;
        end else if (outer_n || inner_n) begin
            door_timer_n = door_timer_q - 1'b1;
        end
`endif
    end

    assign bus.outer_door_open = outer_q;
    assign bus.inner_door_open = inner_q;
    assign bus.pumping         = pump_q;
    assign bus.venting         = vent_q;
    assign bus.pressurized     = press_q;
    assign bus.reject          = reject_q;
    assign bus.remaining       = remaining_q;

endmodule

// File: tb/tb_airlock_interlock_ctrl.sv
// Scoreboard bench for airlock_interlock_ctrl: stimulus queues expected outputs per edge, a monitor compares.
module tb_airlock_interlock_ctrl;

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] OD   = 6'b100000;
    localparam logic [5:0] ID   = 6'b010000;
    localparam logic [5:0] PU   = 6'b001000;
    localparam logic [5:0] VE   = 6'b000100;
    localparam logic [5:0] PR   = 6'b000010;
    localparam logic [5:0] RJ   = 6'b000001;

    typedef struct {
        string      nm;
        logic [5:0] flags;
        logic [7:0] rem;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    exp_t sb_q[$];

    airlock_interlock_ctrl_if #(.CNT_WIDTH(8)) bus ();

    airlock_interlock_ctrl #(
        .PRESS_CYCLES(8),
        .EVAC_CYCLES (10),
        .CNT_WIDTH   (8),
        .DOOR_TIMEOUT(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input string nm, input logic [5:0] flags, input int rem);
        exp_t e;
        @(posedge clk);
        e.nm    = nm;
        e.flags = flags;
        e.rem   = 8'(rem);
        sb_q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [5:0] act;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {bus.outer_door_open, bus.inner_door_open, bus.pumping,
                   bus.venting, bus.pressurized, bus.reject};
            compared++;
            if (act !== e.flags || bus.remaining !== e.rem) begin
                mismatched++;
                $display("FAIL %s @%0t: got od/id/pu/ve/pr/rj=%b rem=%0d, required %b rem=%0d",
                         e.nm, $time, act, bus.remaining, e.flags, e.rem);
            end
        end
    end

    initial begin
        bus.sw0 = 0; bus.sw1 = 0; bus.sw2 = 0;
        bus.key0 = 0; bus.key1 = 0; bus.key2 = 0;

        // reset with key1 held: no event afterwards
        rst = 1; bus.key1 = 1;
        tick("reset0", PR, 0);
        tick("reset1", PR, 0);
        rst = 0;
        tick("held_key1", PR, 0);
        bus.key1 = 0;
        tick("release_key1", PR, 0);

        // evacuate: 10 vent cycles, remaining 9..0
        bus.key1 = 1;
        tick("evac_start", VE, 9);
        bus.key1 = 0;
        for (int r = 8; r >= 0; r--) tick("evac_count", VE, r);
        tick("evac_idle", NONE, 0);
        bus.sw0 = 1;
        tick("outer_open", OD, 0);
        tick("outer_open2", OD, 0);
        bus.key1 = 1;
        tick("key1_ignored_evac_idle", OD, 0);
        bus.key1 = 0;
        bus.key0 = 1;
        tick("key0_reject_outer", OD | RJ, 0);
        bus.key0 = 0;
        tick("reject_one_cycle", OD, 0);
        bus.sw0 = 0;
        tick("outer_close", NONE, 0);
        bus.sw1 = 1;
        tick("inner_wrong_state", NONE, 0);
        bus.sw1 = 0;

        // pressurize with key1 ignored mid-phase
        bus.key0 = 1;
        tick("press_start", PU, 7);
        bus.key0 = 0; bus.key1 = 1;
        tick("key1_ignored_phase", PU, 6);
        bus.key1 = 0;
        for (int r = 5; r >= 0; r--) tick("press_count", PU, r);
        tick("press_idle", PR, 0);

        // inner door and reject in PRESS_IDLE
        bus.sw1 = 1;
        tick("inner_open", ID | PR, 0);
        bus.key1 = 1;
        tick("key1_reject_inner", ID | PR | RJ, 0);
        bus.key1 = 0;
        tick("inner_stays", ID | PR, 0);
        bus.sw0 = 1;
        tick("outer_wrong_state", ID | PR, 0);
        bus.sw0 = 0; bus.sw1 = 0;
        tick("inner_close", PR, 0);
        bus.key0 = 1;
        tick("key0_ignored_press_idle", PR, 0);
        bus.key0 = 0;
        tick("press_idle_quiet", PR, 0);

        // hold at remaining=5 for 4 cycles: 14 vent cycles total
        bus.key1 = 1;
        tick("hold_evac_start", VE, 9);
        bus.key1 = 0;
        for (int r = 8; r >= 5; r--) tick("hold_pre", VE, r);
        bus.sw2 = 1;
        for (int i = 0; i < 4; i++) tick("hold_frozen", VE, 5);
        bus.sw2 = 0;
        for (int r = 4; r >= 0; r--) tick("hold_post", VE, r);
        tick("hold_evac_idle", NONE, 0);

        // abort during pressurize, then abort+key0 during evacuate
        bus.key0 = 1;
        tick("abort_press_start", PU, 7);
        bus.key0 = 0;
        for (int r = 6; r >= 3; r--) tick("abort_press_count", PU, r);
        bus.key2 = 1;
        tick("abort_to_vent", VE, 9);
        bus.key2 = 0;
        tick("abort_vent_count", VE, 8);
        bus.key0 = 1; bus.key2 = 1;
        tick("abort_wins_no_reject", PU, 7);
        bus.key0 = 0; bus.key2 = 0;
        tick("after_abort", PU, 6);
        bus.sw2 = 1;
        tick("hold_press", PU, 6);
        bus.key2 = 1;
        tick("abort_under_hold", VE, 9);
        bus.key2 = 0;
        tick("hold_vent", VE, 9);
        bus.sw2 = 0;
        for (int r = 8; r >= 0; r--) tick("abort_vent_drain", VE, r);
        tick("abort_evac_idle", NONE, 0);
        bus.key2 = 1;
        tick("key2_ignored_idle", NONE, 0);
        bus.key2 = 0;

        // reset mid-phase with other inputs active
        bus.key0 = 1;
        tick("rst_phase_start", PU, 7);
        bus.key0 = 0;
        tick("rst_phase_count", PU, 6);
        rst = 1; bus.key1 = 1; bus.sw0 = 1;
        tick("mid_phase_reset", PR, 0);
        rst = 0;
        tick("post_reset_key_held", PR, 0);
        bus.key1 = 0; bus.sw0 = 0;
        tick("post_reset_quiet", PR, 0);

`ifdef AIRLOCK_AUTO_CLOSE_EN
        bus.key1 = 1;
        tick("ac_evac_start", VE, 9);
        bus.key1 = 0;
        for (int r = 8; r >= 0; r--) tick("ac_evac_count", VE, r);
        tick("ac_evac_idle", NONE, 0);
        bus.sw0 = 1;
        for (int i = 0; i < 6; i++) tick("ac_outer_open", OD, 0);
        tick("ac_timeout_close", NONE, 0);
        tick("ac_stays_closed", NONE, 0);
        bus.sw0 = 0;
        tick("ac_switch_low", NONE, 0);
        bus.sw0 = 1;
        tick("ac_reopen", OD, 0);
        bus.sw0 = 0;
        tick("ac_close", NONE, 0);
`endif

        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/airlock_interlock_ctrl.md
Name: airlock_interlock_ctrl

Overview:
Airlock interlock controller, the responding end of the switch/key stimulus interface the lab tester drives.
- Sequences a two-door chamber between pressurized and evacuated states using timed pump and vent phases.
- Enforces the interlock: the outer door opens only when the chamber is evacuated, the inner door only when it is pressurized, and never both.
- Sits between the board switches/keys and the door, pump and status LEDs.

Parameters:
- PRESS_CYCLES, 8: pump-phase duration in clock cycles (1 .. 2^CNT_WIDTH-1).
- EVAC_CYCLES, 10: vent-phase duration in clock cycles (1 .. 2^CNT_WIDTH-1).
- CNT_WIDTH, 8: phase/door counter width.
- DOOR_TIMEOUT, 6: auto-close limit in cycles; used only with AIRLOCK_AUTO_CLOSE_EN.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high.
- SW0  in  1  outer door open request (level).
- SW1  in  1  inner door open request (level).
- SW2  in  1  hold: freezes the phase counter while high.
- Key0  in  1  pressurize command (rising-edge event).
- Key1  in  1  evacuate command (rising-edge event).
- Key2  in  1  abort/reverse command (rising-edge event).
- OuterDoorOpen  out  1  outer door actuator.
- InnerDoorOpen  out  1  inner door actuator.
- Pumping  out  1  pump active (PRESSURIZING).
- Venting  out  1  vent active (EVACUATING).
- Pressurized  out  1  high in PRESS_IDLE only.
- Reject  out  1  one-cycle pulse on a refused command.
- Remaining  out  CNT_WIDTH  cycles left in current phase; 0 in idle states.

Behaviour:
- All outputs registered.
- Key edge detection
  - KeyPrev registers; event = Key & ~KeyPrev, sampled at a clock edge.
  - On Reset, KeyPrev loads the current Key values, so a key held through reset produces no event.
- Reset values: state=PRESS_IDLE, Pressurized=1, all other outputs 0, counters 0.
- States:
  - PRESS_IDLE
    - InnerDoorOpen <= SW1; OuterDoorOpen=0.
    - Key1 event with SW1=0 and InnerDoorOpen=0: go EVACUATING, Remaining <= EVAC_CYCLES-1.
    - Key1 event with the inner door open or requested: Reject pulse, no transition.
  - EVACUATING
    - Venting=1; both doors 0.
    - Remaining decrements each edge unless SW2=1.
    - At the edge where Remaining==0 and SW2=0: go EVAC_IDLE.
    - Venting is high for exactly EVAC_CYCLES cycles when SW2 stays low.
  - EVAC_IDLE
    - OuterDoorOpen <= SW0; InnerDoorOpen=0.
    - Key0 event with SW0=0 and OuterDoorOpen=0: go PRESSURIZING, Remaining <= PRESS_CYCLES-1.
    - Otherwise a Key0 event gives a Reject pulse.
  - PRESSURIZING
    - Mirror of EVACUATING with Pumping=1; ends in PRESS_IDLE.
- Latency
  - A command event sampled at edge N changes state and outputs at edge N; Venting/Pumping are visible in the cycle after N.
  - A door follows its switch one cycle later.
- Abort (Key2)
  - In EVACUATING: go PRESSURIZING with Remaining <= PRESS_CYCLES-1.
  - In PRESSURIZING: go EVACUATING with Remaining <= EVAC_CYCLES-1.
  - Honored while SW2=1.
  - Ignored silently in idle states.
- Irrelevant commands are ignored with no Reject: Key0 in PRESS_IDLE, Key1 in EVAC_IDLE, Key0/Key1 during a phase.
- Simultaneous events: Key2 has priority over Key0/Key1; at most one Reject per cycle.
- Door request in the wrong state (e.g. SW0 high in PRESS_IDLE): door stays closed, no Reject.
- Invariant: OuterDoorOpen & InnerDoorOpen is never 1.
- Reset asserted mid-phase: next edge returns to reset values regardless of other inputs.

Optional Feature:
AIRLOCK_AUTO_CLOSE_EN
- Defined:
  - A door-open timer counts cycles while either door is open.
  - When it reaches DOOR_TIMEOUT, that door closes.
  - The door stays closed until its switch is sampled low then high again.
  - The timer clears when the door closes.
- Undefined: doors follow their switches indefinitely; DOOR_TIMEOUT is unused and no timer logic is built.

Test Plan:
- Reset with Key1 held, then release: Pressurized=1, no state change, Remaining=0, no Reject.
- Key1 pulse with SW1=0: Venting=1 for 10 cycles, Remaining 9..0, then EVAC_IDLE; SW0=1 gives OuterDoorOpen=1 one cycle later.
- SW1=1 (InnerDoorOpen=1), Key1 pulse: Reject high exactly 1 cycle, state stays PRESS_IDLE, InnerDoorOpen stays 1.
- In EVACUATING at Remaining=5, raise SW2 for 4 cycles: Remaining holds 5; after release it resumes, for 14 vent cycles total.
- In PRESSURIZING at Remaining=3, Key2 pulse: Venting=1, Remaining=9; Key0+Key2 together in EVACUATING: abort wins, no Reject.
- With AIRLOCK_AUTO_CLOSE_EN, SW0 held high in EVAC_IDLE: OuterDoorOpen high 6 cycles then 0; reopens only after SW0 toggles low then high.
